// File: rtl/clock_set_ctrl.sv
// rtl/clock_set_ctrl.sv - set-mode FSM and button/UART increment-pulse arbiter (optional CLOCK_SET_CTRL_AUTOREPEAT_EN)
module clock_set_ctrl #(
    parameter int PULSE_GAP     = 2,
    parameter int HOLD_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_up_level,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       o_btn_hour,
    output logic       o_btn_min,
    output logic       o_btn_sec,
    output logic [1:0] o_mode,
    output logic       o_drop
);

    // Field targets share the SET_x mode encoding: 1=sec, 2=min, 3=hour.
    localparam logic [1:0] MODE_RUN = 2'd0;

    logic [1:0] mode_q, mode_d;
    logic       btn_v_q, uart_v_q;
    logic [1:0] btn_t_q, uart_t_q;
    logic [3:0] gap_q;
    logic [2:0] pulse_q;
    logic       drop_q;

    logic       uart_adv, uart_run, uart_req;
    logic [1:0] uart_req_t;
    logic       auto_req, btn_req;
    logic       btn_have, uart_have, can_issue, issue_btn, issue_uart;
    logic [1:0] btn_sel_t, uart_sel_t, issue_t;
    logic       drop_d;

    always_comb begin
        uart_adv   = rx_valid && (rx_data == 8'h4E);
        uart_run   = rx_valid && (rx_data == 8'h52);
        uart_req   = 1'b0;
        uart_req_t = 2'd0;
        if (rx_valid) begin
            case (rx_data)
                8'h48, 8'h68: begin uart_req = 1'b1; uart_req_t = 2'd3; end
                8'h4D, 8'h6D: begin uart_req = 1'b1; uart_req_t = 2'd2; end
                8'h53, 8'h73: begin uart_req = 1'b1; uart_req_t = 2'd1; end
                default:      begin uart_req = 1'b0; uart_req_t = 2'd0; end
            endcase
        end
    end

    // Mode FSM: state register
    always_ff @(posedge clk) begin
        if (rst) mode_q <= MODE_RUN;
        else     mode_q <= mode_d;
    end

    // Mode FSM: next state; a mode-affecting UART byte overrides btn_mode
    always_comb begin
        mode_d = mode_q;
        if (uart_run)
            mode_d = MODE_RUN;
        else if (uart_adv || btn_mode)
            mode_d = mode_q + 2'd1;
    end

    // Mode FSM: outputs
    always_comb begin
        o_mode = mode_q;
    end

`ifdef CLOCK_SET_CTRL_AUTOREPEAT_EN
    logic [31:0] hold_cnt;
    logic        rpt_armed;
    logic        hold_hit;

    assign hold_hit = rpt_armed ? (hold_cnt == 32'(REPEAT_CYCLES - 1))
                                : (hold_cnt == 32'(HOLD_CYCLES - 1));
    assign auto_req = btn_up_level && (mode_q != MODE_RUN) && hold_hit;

    always_ff @(posedge clk) begin
        if (rst || !btn_up_level || (mode_d != mode_q) || (mode_q == MODE_RUN)) begin
            hold_cnt  <= 32'd0;
            rpt_armed <= 1'b0;
        end else if (hold_hit) begin
            hold_cnt  <= 32'd0;
            rpt_armed <= 1'b1;
        end else begin
            hold_cnt  <= hold_cnt + 32'd1;
        end
    end
`else
    localparam int UNUSED_CFG = HOLD_CYCLES + REPEAT_CYCLES;
    logic unused_level;
    assign unused_level = btn_up_level ^ (UNUSED_CFG == 0);
    assign auto_req     = 1'b0;
`endif

    assign btn_req = (btn_up || auto_req) && (mode_q != MODE_RUN);

    // An empty slot lets a fresh request straight through to the output register.
    always_comb begin
        btn_have   = btn_v_q || btn_req;
        btn_sel_t  = btn_v_q ? btn_t_q : mode_q;
        uart_have  = uart_v_q || uart_req;
        uart_sel_t = uart_v_q ? uart_t_q : uart_req_t;
        can_issue  = (gap_q == 4'd0);
        issue_btn  = can_issue && btn_have;
        issue_uart = can_issue && !btn_have && uart_have;
        issue_t    = issue_btn ? btn_sel_t : (issue_uart ? uart_sel_t : 2'd0);
        drop_d     = (btn_v_q && btn_req && !issue_btn) ||
                     (uart_v_q && uart_req && !issue_uart);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_v_q  <= 1'b0;
            btn_t_q  <= 2'd0;
            uart_v_q <= 1'b0;
            uart_t_q <= 2'd0;
            gap_q    <= 4'd0;
            pulse_q  <= 3'd0;
            drop_q   <= 1'b0;
        end else begin
            if (issue_btn) begin
                btn_v_q <= btn_v_q && btn_req;
                btn_t_q <= mode_q;
            end else if (!btn_v_q && btn_req) begin
                btn_v_q <= 1'b1;
                btn_t_q <= mode_q;
            end

            if (issue_uart) begin
                uart_v_q <= uart_v_q && uart_req;
                uart_t_q <= uart_req_t;
            end else if (!uart_v_q && uart_req) begin
                uart_v_q <= 1'b1;
                uart_t_q <= uart_req_t;
            end

            if (issue_btn || issue_uart)
                gap_q <= 4'(PULSE_GAP - 1);
            else if (gap_q != 4'd0)
                gap_q <= gap_q - 4'd1;

            pulse_q <= {issue_t == 2'd3, issue_t == 2'd2, issue_t == 2'd1};
            drop_q  <= drop_d;
        end
    end

    assign o_btn_hour = pulse_q[2];
    assign o_btn_min  = pulse_q[1];
    assign o_btn_sec  = pulse_q[0];
    assign o_drop     = drop_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb/tb_clock_set_ctrl.sv - self-checking bench for clock_set_ctrl against a cycle-level reference model
module tb_clock_set_ctrl;

    localparam int GAP = 2;
    localparam logic [3:0] I  = 4'b0000;
    localparam logic [3:0] RS = 4'b1000;
    localparam logic [3:0] BM = 4'b0100;
    localparam logic [3:0] BU = 4'b0010;
    localparam logic [3:0] RV = 4'b0001;

    logic       clk = 1'b0;
    logic       rst, btn_mode, btn_up, btn_up_level, rx_valid;
    logic [7:0] rx_data;
    logic       o_btn_hour, o_btn_min, o_btn_sec, o_drop;
    logic [1:0] o_mode;

    int checks = 0;
    int errors = 0;

    int m_mode, m_bslot, m_uslot, m_cyc, m_last;
    logic [5:0] exp_o;

    clock_set_ctrl #(.PULSE_GAP(GAP), .HOLD_CYCLES(10), .REPEAT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_up(btn_up),
        .btn_up_level(btn_up_level), .rx_data(rx_data), .rx_valid(rx_valid),
        .o_btn_hour(o_btn_hour), .o_btn_min(o_btn_min), .o_btn_sec(o_btn_sec),
        .o_mode(o_mode), .o_drop(o_drop)
    );

    always #5 clk = ~clk;

    function automatic int uart_target(input logic [7:0] d);
        case (d)
            "H", "h": return 3;
            "M", "m": return 2;
            "S", "s": return 1;
            default:  return 0;
        endcase
    endfunction

    // Reference: one issue per PULSE_GAP cycles, button source first, one waiting request per source.
    task automatic model_step(input logic r, bm, bu, rv, input logic [7:0] d);
        int breq, ureq, bc, uc, tgt;
        bit from_btn, drop;
        if (r) begin
            m_mode = 0; m_bslot = 0; m_uslot = 0; m_last = -1000;
            exp_o = 6'd0;
        end else begin
            breq = (bu && m_mode != 0) ? m_mode : 0;
            ureq = rv ? uart_target(d) : 0;
            bc = (m_bslot != 0) ? m_bslot : breq;
            uc = (m_uslot != 0) ? m_uslot : ureq;
            tgt = 0; from_btn = 0;
            if (m_cyc - m_last >= GAP) begin
                if (bc != 0) begin tgt = bc; from_btn = 1; end
                else tgt = uc;
            end
            if (tgt != 0) m_last = m_cyc;
            drop = (m_bslot != 0 && breq != 0 && !(tgt != 0 && from_btn)) ||
                   (m_uslot != 0 && ureq != 0 && !(tgt != 0 && !from_btn));
            if (tgt != 0 && from_btn) m_bslot = (m_bslot != 0) ? breq : 0;
            else if (m_bslot == 0)    m_bslot = breq;
            if (tgt != 0 && !from_btn) m_uslot = (m_uslot != 0) ? ureq : 0;
            else if (m_uslot == 0)     m_uslot = ureq;
            if (rv && d == "R")                  m_mode = 0;
            else if ((rv && d == "N") || bm)     m_mode = (m_mode + 1) % 4;
            exp_o = {2'(m_mode), tgt == 3, tgt == 2, tgt == 1, drop};
        end
        m_cyc++;
    endtask

    task automatic tick(input logic [11:0] v);
        rst = v[11]; btn_mode = v[10]; btn_up = v[9]; rx_valid = v[8]; rx_data = v[7:0];
        btn_up_level = 1'b0;
        @(posedge clk);
        model_step(v[11], v[10], v[9], v[8], v[7:0]);
        #1;
    endtask

    task automatic test_reset();
        logic [11:0] s [0:6];
        s = '{{RS, 8'h0}, {RS, 8'h0}, {RS, 8'h0}, {I, 8'h0}, {BU, 8'h0}, {I, 8'h0}, {I, 8'h0}};
        foreach (s[i]) begin
            tick(s[i]);
            checks++;
            if ({o_mode, o_btn_hour, o_btn_min, o_btn_sec, o_drop} !== exp_o) begin
                errors++;
                $display("FAIL reset step %0d: mode/h/m/s/drop got %b expected %b", i,
                         {o_mode, o_btn_hour, o_btn_min, o_btn_sec, o_drop}, exp_o);
            end
        end
        checks++;
        if ({o_mode, o_btn_hour, o_btn_min, o_btn_sec, o_drop} !== 6'd0) begin
            errors++;
            $display("FAIL reset_idle: got %b expected 000000",
                     {o_mode, o_btn_hour, o_btn_min, o_btn_sec, o_drop});
        end
    endtask

    task automatic test_set_sec();
        logic [11:0] s [0:8];
        s = '{{RS, 8'h0}, {BM, 8'h0}, {BU, 8'h0}, {I, 8'h0}, {I, 8'h0},
              {BM, 8'h0}, {BM, 8'h0}, {BM, 8'h0}, {I, 8'h0}};
        foreach (s[i]) begin
            tick(s[i]);
            checks++;
            if ({o_mode, o_btn_hour, o_btn_min, o_btn_sec, o_drop} !== exp_o) begin
                errors++;
                $display("FAIL set_sec step %0d: mode/h/m/s/drop got %b expected %b", i,
                         {o_mode, o_btn_hour, o_btn_min, o_btn_sec, o_drop}, exp_o);
            end
        end
    endtask

    task automatic test_dual_source();
        logic [11:0] s [0:7];
        s = '{{RS, 8'h0}, {BM, 8'h0}, {BM, 8'h0}, {BU | RV, "h"},
              {I, 8'h0}, {I, 8'h0}, {I, 8'h0}, {I, 8'h0}};
        foreach (s[i]) begin
            tick(s[i]);
            checks++;
            if ({o_mode, o_btn_hour, o_btn_min, o_btn_sec, o_drop} !== exp_o) begin
                errors++;
                $display("FAIL dual_source step %0d: mode/h/m/s/drop got %b expected %b", i,
                         {o_mode, o_btn_hour, o_btn_min, o_btn_sec, o_drop}, exp_o);
            end
        end
    endtask

    task automatic test_uart_drop();
        logic [11:0] s [0:13];
        s = '{{RS, 8'h0}, {RV, "S"}, {RV, "S"}, {I, 8'h0}, {I, 8'h0}, {RV, "x"}, {I, 8'h0},
              {BM, 8'h0}, {BU | RV, "m"}, {BU | RV, "m"}, {I, 8'h0}, {I, 8'h0}, {I, 8'h0}, {I, 8'h0}};
        foreach (s[i]) begin
            tick(s[i]);
            checks++;
            if ({o_mode, o_btn_hour, o_btn_min, o_btn_sec, o_drop} !== exp_o) begin
                errors++;
                $display("FAIL uart_drop step %0d: mode/h/m/s/drop got %b expected %b", i,
                         {o_mode, o_btn_hour, o_btn_min, o_btn_sec, o_drop}, exp_o);
            end
        end
    endtask

    task automatic test_retarget_and_mode();
        logic [11:0] s [0:13];
        s = '{{RS, 8'h0}, {BM, 8'h0}, {BM, 8'h0}, {BM, 8'h0}, {RV, "m"}, {BU, 8'h0}, {BM, 8'h0},
              {I, 8'h0}, {I, 8'h0}, {RV, "N"}, {BM | RV, "R"}, {BM | RV, "N"}, {RV, "R"}, {I, 8'h0}};
        foreach (s[i]) begin
            tick(s[i]);
            checks++;
            if ({o_mode, o_btn_hour, o_btn_min, o_btn_sec, o_drop} !== exp_o) begin
                errors++;
                $display("FAIL retarget step %0d: mode/h/m/s/drop got %b expected %b", i,
                         {o_mode, o_btn_hour, o_btn_min, o_btn_sec, o_drop}, exp_o);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] pool [0:9];
        logic [11:0] v;
        pool = '{"H", "h", "M", "m", "S", "s", "N", "R", "x", 8'h00};
        tick({RS, 8'h0});
        for (int i = 0; i < 3000; i++) begin
            v[11] = ($urandom_range(0, 199) == 0);
            v[10] = ($urandom_range(0, 7) == 0);
            v[9]  = ($urandom_range(0, 2) == 0);
            v[8]  = ($urandom_range(0, 3) == 0);
            v[7:0] = pool[$urandom_range(0, 9)];
            if (v[7:0] == 8'h00) v[7:0] = 8'($urandom);
            tick(v);
            checks++;
            if ({o_mode, o_btn_hour, o_btn_min, o_btn_sec, o_drop} !== exp_o) begin
                errors++;
                $display("FAIL random cycle %0d: mode/h/m/s/drop got %b expected %b", i,
                         {o_mode, o_btn_hour, o_btn_min, o_btn_sec, o_drop}, exp_o);
            end
        end
    endtask

    initial begin
        m_mode = 0; m_bslot = 0; m_uslot = 0; m_cyc = 0; m_last = -1000; exp_o = 6'd0;
        test_reset();
        test_set_sec();
        test_dual_source();
        test_uart_drop();
        test_retarget_and_mode();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
